barrido_estimulo: RTL

Sequential stimulus sweeper that sits directly upstream of the 6-bit "equals 22" comparator and the 3-to-8 decoder. On a start pulse it drives a 6-bit value sweep and a 3-bit decoder select sweep, one step per clock. It samples the comparator's 1-bit response on every step and reports the hit count, the first hit value and a done pulse. It replaces free-running `initial`/`#1` stimulus with a synthesizable, clocked source.

---
 rtl/barrido_pkg.sv | 15 +
 rtl/barrido_if.sv | 30 +++
 rtl/registro_aciertos.sv | 48 ++++
 rtl/barrido_estimulo.sv | 102 ++++++++++
 4 files changed

// File: rtl/barrido_pkg.sv
// Shared definitions for the stimulus sweeper: FSM state encoding and the
// widths of the value, decoder-select and hit-count buses.
package barrido_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'b00,
        BARRIDO = 2'b01,
        FIN     = 2'b10
    } estado_t;

    localparam int ANCHO_ESTIMULO = 6;
    localparam int ANCHO_DEC      = 3;
    localparam int ANCHO_CONTEO   = 7;

endpackage

// File: rtl/barrido_if.sv
// Bundle of the sweeper's control, comparator and result signals.
// The slave modport is the sweeper itself; the master side drives
// start/pause and the comparator response and reads the results.
interface barrido_if;
    import barrido_pkg::*;

    logic                      inicio;
    logic                      pausa;
    logic                      rta_comparador;
    logic [ANCHO_ESTIMULO-1:0] estimulo;
    logic [ANCHO_DEC-1:0]      estimulo_dec;
    logic                      ocupado;
    logic                      listo;
    logic [ANCHO_CONTEO-1:0]   conteo_aciertos;
    logic [ANCHO_ESTIMULO-1:0] primer_acierto;
    logic                      hubo_acierto;

    modport master (
        output inicio, pausa, rta_comparador,
        input  estimulo, estimulo_dec, ocupado, listo,
               conteo_aciertos, primer_acierto, hubo_acierto
    );

    modport slave (
        input  inicio, pausa, rta_comparador,
        output estimulo, estimulo_dec, ocupado, listo,
               conteo_aciertos, primer_acierto, hubo_acierto
    );

endinterface

// File: rtl/registro_aciertos.sv
// Hit bookkeeping for one sweep: hit counter, value of the first hit and
// a sticky "any hit" flag. Cleared at sweep start, updated on active steps.
module registro_aciertos
    import barrido_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      limpiar_i,
    input  logic                      habilitar_i,
    input  logic                      acierto_i,
    input  logic [ANCHO_ESTIMULO-1:0] valor_i,
    output logic [ANCHO_CONTEO-1:0]   conteo_o,
    output logic [ANCHO_ESTIMULO-1:0] primer_o,
    output logic                      hubo_o
);

    logic [ANCHO_CONTEO-1:0]   conteo_q;
    logic [ANCHO_ESTIMULO-1:0] primer_q;
    logic                      hubo_q;
    logic [ANCHO_CONTEO-1:0]   conteo_d;

    // 7 bits hold up to 127, so a full 64-step sweep of hits cannot overflow
    assign conteo_d = conteo_q + 7'd1;

    // Clear on start; count hits and latch the first hit value on active steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conteo_q <= '0;
            primer_q <= '0;
            hubo_q   <= 1'b0;
        end else if (limpiar_i) begin
            conteo_q <= '0;
            primer_q <= '0;
            hubo_q   <= 1'b0;
        end else if (habilitar_i && acierto_i) begin
            conteo_q <= conteo_d;
            if (!hubo_q) begin
                hubo_q   <= 1'b1;
                primer_q <= valor_i;
            end
        end
    end

    assign conteo_o = conteo_q;
    assign primer_o = primer_q;
    assign hubo_o   = hubo_q;

endmodule

// File: rtl/barrido_estimulo.sv
// Clocked stimulus sweeper for the "equals 22" comparator and the 3-to-8
// decoder: on a start request it walks estimulo over 0..LIMITE (decoder
// select follows modulo 8), samples the comparator each step and reports
// the hit results plus a one-cycle done pulse.
// Optional feature macro: BARRIDO_PAUSA_EN (honour the pausa input).
module barrido_estimulo
    import barrido_pkg::*;
#(
    parameter int LIMITE = 62
) (
    input logic      clk,
    input logic      rst_n,
    barrido_if.slave bus
);

    localparam logic [ANCHO_ESTIMULO-1:0] ULTIMO = ANCHO_ESTIMULO'(LIMITE);

    estado_t                   estado_q;
    logic [ANCHO_ESTIMULO-1:0] estimulo_q;
    logic [ANCHO_ESTIMULO-1:0] estimulo_d;
    logic [ANCHO_DEC-1:0]      dec_q;
    logic [ANCHO_DEC-1:0]      dec_d;
    logic                      ocupado_q;
    logic                      listo_q;
    logic                      pausado;
    logic                      arranque;
    logic                      paso_activo;

`ifdef BARRIDO_PAUSA_EN
    assign pausado = bus.pausa;
`else
    // Pause input kept on the bus but has no effect in this build
    logic unused_pausa;
    assign unused_pausa = bus.pausa;
    assign pausado      = 1'b0;
`endif

    assign arranque    = (estado_q == REPOSO) && bus.inicio;
    assign paso_activo = (estado_q == BARRIDO) && !pausado;
    assign estimulo_d  = estimulo_q + 6'd1;
    assign dec_d       = dec_q + 3'd1;

    // Sweep FSM with the value/select counters and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= REPOSO;
            estimulo_q <= '0;
            dec_q      <= '0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (bus.inicio) begin
                        estado_q   <= BARRIDO;
                        estimulo_q <= '0;
                        dec_q      <= '0;
                        ocupado_q  <= 1'b1;
                    end
                end
                BARRIDO: begin
                    if (!pausado) begin
                        if (estimulo_q == ULTIMO) begin
                            estado_q  <= FIN;
                            ocupado_q <= 1'b0;
                            listo_q   <= 1'b1;
                        end else begin
                            estimulo_q <= estimulo_d;
                            dec_q      <= dec_d;
                        end
                    end
                end
                FIN: begin
                    estado_q <= REPOSO;
                end
                default: begin
                    estado_q  <= REPOSO;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    registro_aciertos u_aciertos (
        .clk         (clk),
        .rst_n       (rst_n),
        .limpiar_i   (arranque),
        .habilitar_i (paso_activo),
        .acierto_i   (bus.rta_comparador),
        .valor_i     (estimulo_q),
        .conteo_o    (bus.conteo_aciertos),
        .primer_o    (bus.primer_acierto),
        .hubo_o      (bus.hubo_acierto)
    );

    assign bus.estimulo     = estimulo_q;
    assign bus.estimulo_dec = dec_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.listo        = listo_q;

endmodule
